seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised multi-cycle ALU for the MIPS datapath. It generalises the combinational 32-bit ALU in three ways:

- adds a WIDTH parameter;
- adds unsigned multiply and divide, which run iteratively over WIDTH cycles and write a HI register;
- replaces the combinational result path with a start/busy/done handshake on registered outputs.

It sits between the register-file read stage and write-back, and the control unit stalls on `busy`.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when `busy`=0.
- operation  in  4  opcode, captured with `start`.
- a  in  WIDTH  operand A, captured with `start`.
- b  in  WIDTH  operand B, captured with `start`.
- busy  out  1  a MUL or DIV operation is in progress.
- done  out  1  one-cycle pulse; `result`, `hi` and the flags are valid and updated.
- result  out  WIDTH  low/primary result (registered).
- hi  out  WIDTH  MUL upper half or DIV remainder (registered).
- zero  out  1  `result`==0, registered together with `result`.
- overflow  out  1  signed overflow of ADD/SUB.
- div_by_zero  out  1  the last DIV had b==0.

## Operation
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT
  - 1000 MUL
  - 1001 DIV
  - every other code is NOP
- State machine has three states: IDLE, MUL, DIV.
- Accepting a request: `start`=1 in IDLE latches `a`, `b` and `operation`. `start` in any other state is ignored and nothing is queued.
- Single-cycle ops (AND, OR, ADD, SUB, SLT, NOP): the FSM stays in IDLE. `result` is written at the accepting edge and `done`=1 for the following cycle. NOP writes `result`=0.
- ADD/SUB: modulo 2^WIDTH. `overflow` = signed overflow, i.e. operand signs equal (ADD) or different (SUB) and result sign differs from A. Every other op clears `overflow`.
- SLT: signed compare. `result` = 1 if a<b, else 0; upper bits are 0. The compare must be correct even when a−b overflows (use sign of difference XOR overflow).
- MUL: unsigned shift-add, one bit per cycle.
  - IDLE→MUL on accept; an internal counter runs WIDTH cycles.
  - On completion, {hi,result} = a*b (2·WIDTH bits).
- DIV: unsigned restoring division, one quotient bit per cycle.
  - IDLE→DIV on accept; the counter runs WIDTH cycles.
  - On completion, `result` = quotient and `hi` = remainder.
  - b==0 still takes WIDTH cycles and yields quotient = all ones, remainder = a, `div_by_zero`=1.
  - A DIV with b≠0 clears `div_by_zero`. Other ops leave `div_by_zero` unchanged.
- MUL/DIV return to IDLE on completion. They do not touch `overflow`, apart from clearing it at completion.
- `hi` is written only by MUL/DIV.
- `result`, `hi`, `zero` and the flags hold their values between completions.
- Intermediate iteration state is never visible on the outputs.

## Timing
- Reset values: state=IDLE, counter=0, `busy`=0, `done`=0, `result`=0, `hi`=0, `zero`=1, `overflow`=0, `div_by_zero`=0.
- Single-cycle op accepted at edge k: outputs update at edge k; `done`=1 from edge k to k+1. Latency is 1, and a new `start` may be accepted at edge k+1 (back-to-back throughput of 1 per cycle).
- MUL/DIV accepted at edge k:
  - `busy`=1 from edge k to k+WIDTH.
  - At edge k+WIDTH: `busy`→0, outputs update, and `done`=1 for one cycle.
  - The next `start` may be accepted at edge k+WIDTH+1; `start` at edge k+WIDTH is ignored because `busy` is still high at that edge.
- `done` is never high for two consecutive cycles from a single request.
- `rst` mid-operation aborts the operation at that edge: all outputs go to reset values, no `done` is produced, and a `start` in the same cycle as `rst` is dropped.
- `operation`, `a` and `b` may change freely while `busy`=1.

## Test plan
- WIDTH=32: ADD a=0x7FFFFFFF, b=1 → result=0x80000000, overflow=1, zero=0, done pulses one cycle after start.
- SUB a=5, b=5 → result=0, zero=1, overflow=0. SLT a=0x80000000, b=0x00000001 → result=1, despite the subtraction overflowing.
- MUL a=b=0xFFFFFFFF → busy high for 32 cycles, then hi=0xFFFFFFFE, result=0x00000001, done for exactly 1 cycle.
- DIV a=100, b=7 → result=14, hi=2, div_by_zero=0. DIV a=0x1234, b=0 → result=0xFFFFFFFF, hi=0x1234, div_by_zero=1, latency 32.
- Start an ADD while a MUL is busy → ignored: no extra done, MUL result correct. Assert `rst` at cycle 10 of a DIV → all outputs at reset values and no done.
- WIDTH=8: MUL 0xFF*0xFF → hi=0xFE, result=0x01 after 8 cycles. Back-to-back AND/OR → one done per cycle.

Source files
------------

// File: rtl/seq_alu_if.sv
// Request/response bundle for the multi-cycle ALU: operands and opcode in,
// registered results, flags and the start/busy/done handshake out.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output start, operation, a, b,
    input  busy, done, result, hi, zero, overflow, div_by_zero
  );

  modport slave (
    input  start, operation, a, b,
    output busy, done, result, hi, zero, overflow, div_by_zero
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: logic/arith/compare ops finish in one cycle, unsigned
// MUL (shift-add) and DIV (restoring) iterate one bit per cycle.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic             accept;
  logic             last_iter;

  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] hi_q;
  logic             zero_q;
  logic             overflow_q;
  logic             div_by_zero_q;
  logic             done_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt_bit;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_hi_next;
  logic [WIDTH-1:0] div_lo_next;

  assign accept    = bus.start && (state == IDLE);
  assign last_iter = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && bus.operation == OP_MUL)      state_next = MUL;
        else if (accept && bus.operation == OP_DIV) state_next = DIV;
      end
      MUL, DIV: if (last_iter) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
  end

  // SLT uses sign-of-difference XOR overflow so it stays correct when a-b wraps.
  assign sum     = bus.a + bus.b;
  assign diff    = bus.a - bus.b;
  assign add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1]  != bus.a[WIDTH-1]);
  assign sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
  assign slt_bit = diff[WIDTH-1] ^ sub_ovf;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.operation)
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_ADD: begin alu_res = sum;  alu_ovf = add_ovf; end
      OP_SUB: begin alu_res = diff; alu_ovf = sub_ovf; end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      default: alu_res = '0;
    endcase
  end

  // MUL: {work_hi, work_lo} shifts right, adding the multiplicand when the LSB is set.
  assign mul_sum     = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], work_lo[WIDTH-1:1]};

  // DIV: work_hi is the partial remainder, work_lo shifts dividend out and quotient in.
  // A zero divisor naturally yields all-ones quotient and remainder = dividend.
  assign div_shift   = {work_hi, work_lo[WIDTH-1]};
  assign div_ge      = div_shift >= {1'b0, opnd};
  assign div_diff    = div_shift[WIDTH-1:0] - opnd;
  assign div_hi_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign div_lo_next = {work_lo[WIDTH-2:0], div_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      opnd          <= '0;
      work_hi       <= '0;
      work_lo       <= '0;
      result_q      <= '0;
      hi_q          <= '0;
      zero_q        <= 1'b1;
      overflow_q    <= 1'b0;
      div_by_zero_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            count <= '0;
            if (bus.operation == OP_MUL) begin
              opnd    <= bus.a;
              work_hi <= '0;
              work_lo <= bus.b;
            end else if (bus.operation == OP_DIV) begin
              opnd    <= bus.b;
              work_hi <= '0;
              work_lo <= bus.a;
            end else begin
              result_q   <= alu_res;
              zero_q     <= (alu_res == '0);
              overflow_q <= alu_ovf;
              done_q     <= 1'b1;
            end
          end
        end
        MUL: begin
          count   <= count + 1'b1;
          work_hi <= mul_hi_next;
          work_lo <= mul_lo_next;
          if (last_iter) begin
            count      <= '0;
            result_q   <= mul_lo_next;
            hi_q       <= mul_hi_next;
            zero_q     <= (mul_lo_next == '0);
            overflow_q <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        DIV: begin
          count   <= count + 1'b1;
          work_hi <= div_hi_next;
          work_lo <= div_lo_next;
          if (last_iter) begin
            count         <= '0;
            result_q      <= div_lo_next;
            hi_q          <= div_hi_next;
            zero_q        <= (div_lo_next == '0);
            overflow_q    <= 1'b0;
            div_by_zero_q <= (opnd == '0);
            done_q        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.hi          = hi_q;
  assign bus.zero        = zero_q;
  assign bus.overflow    = overflow_q;
  assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a 32-bit and an 8-bit instance driven with
// directed vectors; a negedge monitor pops expectations whenever done is seen.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) bus32 ();
  seq_alu_if #(.WIDTH(8))  bus8 ();

  seq_alu #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct {
    logic [31:0] result;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        dbz;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   total = 0;
  int   bad = 0;

  function automatic exp_t mk(logic [31:0] r, logic [31:0] h, logic z, logic o, logic d);
    exp_t e;
    e.result = r;
    e.hi     = h;
    e.zero   = z;
    e.ovf    = o;
    e.dbz    = d;
    return e;
  endfunction

  task automatic check_output(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus32.done === 1'b1) begin
      if (q32.size() == 0) check_output("w32 unexpected done", 64'd1, 64'd0);
      else begin
        e = q32.pop_front();
        check_output("w32 result",      64'(bus32.result),      64'(e.result));
        check_output("w32 hi",          64'(bus32.hi),          64'(e.hi));
        check_output("w32 zero",        64'(bus32.zero),        64'(e.zero));
        check_output("w32 overflow",    64'(bus32.overflow),    64'(e.ovf));
        check_output("w32 div_by_zero", 64'(bus32.div_by_zero), 64'(e.dbz));
      end
    end
    if (bus8.done === 1'b1) begin
      if (q8.size() == 0) check_output("w8 unexpected done", 64'd1, 64'd0);
      else begin
        e = q8.pop_front();
        check_output("w8 result",      64'(bus8.result),      64'(e.result));
        check_output("w8 hi",          64'(bus8.hi),          64'(e.hi));
        check_output("w8 zero",        64'(bus8.zero),        64'(e.zero));
        check_output("w8 overflow",    64'(bus8.overflow),    64'(e.ovf));
        check_output("w8 div_by_zero", 64'(bus8.div_by_zero), 64'(e.dbz));
      end
    end
  end

  task automatic drive(bit sel8, logic s, logic [3:0] op, logic [31:0] a, logic [31:0] b);
    if (sel8) begin
      bus8.start = s; bus8.operation = op; bus8.a = a[7:0]; bus8.b = b[7:0];
    end else begin
      bus32.start = s; bus32.operation = op; bus32.a = a; bus32.b = b;
    end
  endtask

  function automatic logic is_done(bit sel8);
    return sel8 ? bus8.done : bus32.done;
  endfunction

  function automatic logic is_busy(bit sel8);
    return sel8 ? bus8.busy : bus32.busy;
  endfunction

  // Issue one request; optionally poke an ignored ADD at iteration 'inject'
  // and again on the final busy edge.
  task automatic apply_stimulus(bit sel8, string name, logic [3:0] op, logic [31:0] a,
                                logic [31:0] b, exp_t e, int exp_lat, int inject);
    int cnt;
    int busy_cycles;
    if (sel8) q8.push_back(e);
    else      q32.push_back(e);
    @(negedge clk);
    drive(sel8, 1'b1, op, a, b);
    @(posedge clk);
    #1;
    drive(sel8, 1'b0, op, a, b);
    cnt = 0;
    busy_cycles = 0;
    while (is_done(sel8) !== 1'b1 && cnt < 200) begin
      if (is_busy(sel8) === 1'b1) busy_cycles++;
      if (inject >= 0 && (cnt == inject || cnt == exp_lat - 1))
        drive(sel8, 1'b1, 4'b0010, 32'd1, 32'd1);
      else
        drive(sel8, 1'b0, 4'b0010, 32'd1, 32'd1);
      @(posedge clk);
      #1;
      cnt++;
    end
    drive(sel8, 1'b0, 4'b0000, 32'd0, 32'd0);
    check_output({name, " latency"}, 64'(cnt), 64'(exp_lat));
    check_output({name, " busy cycles"}, 64'(busy_cycles), 64'(exp_lat));
    check_output({name, " busy at done"}, 64'(is_busy(sel8)), 64'd0);
  endtask

  task automatic check_reset(string name);
    check_output({name, " busy"},        64'(bus32.busy),        64'd0);
    check_output({name, " done"},        64'(bus32.done),        64'd0);
    check_output({name, " result"},      64'(bus32.result),      64'd0);
    check_output({name, " hi"},          64'(bus32.hi),          64'd0);
    check_output({name, " zero"},        64'(bus32.zero),        64'd1);
    check_output({name, " overflow"},    64'(bus32.overflow),    64'd0);
    check_output({name, " div_by_zero"}, 64'(bus32.div_by_zero), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global timeout: got running, want finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic d1, d2, d3, d4;
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 4'b0000, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    check_output("w8 reset zero", 64'(bus8.zero), 64'd1);
    check_output("w8 reset busy", 64'(bus8.busy), 64'd0);
    rst = 1'b0;

    apply_stimulus(0, "add ovf",  4'b0010, 32'h7FFFFFFF, 32'h1,        mk(32'h80000000, 0, 0, 1, 0), 0, -1);
    apply_stimulus(0, "sub zero", 4'b0110, 32'd5,        32'd5,        mk(32'h0, 0, 1, 0, 0), 0, -1);
    apply_stimulus(0, "slt wrap", 4'b0111, 32'h80000000, 32'h1,        mk(32'h1, 0, 0, 0, 0), 0, -1);
    apply_stimulus(0, "and",      4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, mk(32'h00F000F0, 0, 0, 0, 0), 0, -1);
    apply_stimulus(0, "or",       4'b0001, 32'h12340000, 32'h00005678, mk(32'h12345678, 0, 0, 0, 0), 0, -1);
    apply_stimulus(0, "nop",      4'b1111, 32'hFFFFFFFF, 32'h1,        mk(32'h0, 0, 1, 0, 0), 0, -1);
    apply_stimulus(0, "mul max",  4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(32'h1, 32'hFFFFFFFE, 0, 0, 0), 32, -1);
    apply_stimulus(0, "div 100/7", 4'b1001, 32'd100,     32'd7,        mk(32'd14, 32'd2, 0, 0, 0), 32, -1);
    apply_stimulus(0, "div by 0", 4'b1001, 32'h1234,     32'h0,        mk(32'hFFFFFFFF, 32'h1234, 0, 0, 1), 32, -1);
    apply_stimulus(0, "add keep", 4'b0010, 32'd3,        32'd4,        mk(32'd7, 32'h1234, 0, 0, 1), 0, -1);
    apply_stimulus(0, "mul inj",  4'b1000, 32'h10000,    32'h30000,    mk(32'h0, 32'h3, 1, 0, 1), 32, 5);
    apply_stimulus(0, "sub ovf",  4'b0110, 32'h80000000, 32'h1,        mk(32'h7FFFFFFF, 32'h3, 0, 1, 1), 0, -1);

    // Abort a DIV with reset; the ADD presented alongside reset must be dropped.
    @(negedge clk);
    drive(1'b0, 1'b1, 4'b1001, 32'd1000, 32'd3);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 4'b1001, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b1, 4'b0010, 32'd5, 32'd5);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
    check_reset("abort");
    repeat (40) @(posedge clk);
    #1;
    check_output("abort idle busy", 64'(bus32.busy), 64'd0);

    apply_stimulus(0, "add wrap", 4'b0010, 32'hFFFFFFFF, 32'h1, mk(32'h0, 0, 1, 0, 0), 0, -1);

    apply_stimulus(1, "w8 mul",    4'b1000, 32'hFF, 32'hFF, mk(32'h01, 32'hFE, 0, 0, 0), 8, -1);
    apply_stimulus(1, "w8 div0",   4'b1001, 32'd200, 32'd0, mk(32'hFF, 32'hC8, 0, 0, 1), 8, -1);
    apply_stimulus(1, "w8 div",    4'b1001, 32'd255, 32'd16, mk(32'h0F, 32'h0F, 0, 0, 0), 8, -1);
    apply_stimulus(1, "w8 add ovf", 4'b0010, 32'h7F, 32'h01, mk(32'h80, 32'h0F, 0, 1, 0), 0, -1);

    // Back-to-back single-cycle ops: one done per cycle.
    q8.push_back(mk(32'h30, 32'h0F, 0, 0, 0));
    q8.push_back(mk(32'hFC, 32'h0F, 0, 0, 0));
    q8.push_back(mk(32'h00, 32'h0F, 1, 0, 0));
    @(negedge clk);
    drive(1'b1, 1'b1, 4'b0000, 32'hF0, 32'h3C);
    @(posedge clk);
    #1;
    d1 = bus8.done;
    drive(1'b1, 1'b1, 4'b0001, 32'hF0, 32'h0C);
    @(posedge clk);
    #1;
    d2 = bus8.done;
    drive(1'b1, 1'b1, 4'b0000, 32'h0F, 32'hF0);
    @(posedge clk);
    #1;
    d3 = bus8.done;
    drive(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    d4 = bus8.done;
    check_output("w8 b2b dones", 64'({d1, d2, d3, d4}), 64'b1110);

    repeat (3) @(posedge clk);
    check_output("scoreboard drained", 64'(q32.size() + q8.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
